// File: rtl/sd_audio_reader.sv
// Sector-streaming audio front end: fetches SD sectors into a 512-word FIFO and serves samples to the DAC.
// Optional build macro SD_AUDIO_LOOP_EN: restart at START_SEC after the last sector instead of stopping.
module sd_audio_reader #(
    parameter logic [31:0] START_SEC = 32'd0,
    parameter logic [31:0] SEC_NUM   = 32'd1024,
    parameter logic [7:0]  BUSY_TMO  = 8'd255
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        play_en,
    input  logic        rd_busy,
    input  logic        rd_val_en,
    input  logic [15:0] rd_val_data,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    input  logic        sample_req,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    output logic [9:0]  fifo_level,
    output logic        underrun,
    output logic        sec_err,
    output logic        play_done
);

    typedef enum logic [2:0] {
        IDLE, CHECK, START, WAIT_BUSY, READ, NEXT, DONE
    } state_t;

    localparam logic [31:0] LAST_SEC = START_SEC + SEC_NUM - 32'd1;

    state_t      r_state;
    state_t      w_next;
    logic        w_start;
    logic        w_done;

    logic [31:0] r_sec_addr;
    logic [8:0]  r_word_cnt;
    logic [7:0]  r_tmo;
    logic        r_sec_err;
    logic        r_underrun;

    logic [15:0] r_mem [512];
    logic [9:0]  r_wr_cnt;
    logic [9:0]  r_rd_cnt;
    logic [9:0]  r_level;
    logic [15:0] r_sample_data;
    logic        r_sample_valid;

    logic        w_full;
    logic        w_empty;
    logic        w_room;
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_tmo_hit;
    logic        w_last;
    logic [9:0]  w_wr_cnt_nxt;
    logic [9:0]  w_rd_cnt_nxt;

    assign w_full    = (r_level == 10'd512);
    assign w_empty   = (r_level == '0);
    assign w_room    = (r_level <= 10'd256);
    assign w_tmo_hit = (r_tmo == BUSY_TMO - 8'd1);
    assign w_last    = (r_sec_addr == LAST_SEC);

    // Words past 256 in one sector are dropped so the CHECK room guarantee holds.
    assign w_wr_en = (r_state == READ) && rd_val_en && (r_word_cnt != 9'd256) && !w_full;
    assign w_rd_en = sample_req && !w_empty;

    assign w_wr_cnt_nxt = r_wr_cnt + {9'd0, w_wr_en};
    assign w_rd_cnt_nxt = r_rd_cnt + {9'd0, w_rd_en};

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            IDLE:      if (play_en && sd_init_done) w_next = CHECK;
            CHECK: begin
                if (!play_en)    w_next = IDLE;
                else if (w_room) w_next = START;
            end
            START: begin
                w_start = 1'b1;
                w_next  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (rd_busy)        w_next = READ;
                else if (w_tmo_hit) w_next = START;
            end
            READ:      if (!rd_busy) w_next = NEXT;
            NEXT: begin
`ifdef SD_AUDIO_LOOP_EN
                w_next = CHECK;
`else
                w_next = w_last ? DONE : CHECK;
`endif
            end
            DONE: begin
                w_done = 1'b1;
                if (!play_en) w_next = IDLE;
            end
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_addr <= START_SEC;
            r_word_cnt <= '0;
            r_tmo      <= '0;
            r_sec_err  <= 1'b0;
        end else begin
            unique case (r_state)
                START: begin
                    r_word_cnt <= '0;
                    r_tmo      <= '0;
                end
                WAIT_BUSY: begin
                    if (!rd_busy) begin
                        if (w_tmo_hit) r_sec_err <= 1'b1;
                        else           r_tmo     <= r_tmo + 8'd1;
                    end
                end
                READ: begin
                    if (w_wr_en) r_word_cnt <= r_word_cnt + 9'd1;
                    if (rd_val_en && !w_wr_en) r_sec_err <= 1'b1;
                    if (!rd_busy && (r_word_cnt != 9'd256)) r_sec_err <= 1'b1;
                end
                NEXT: begin
                    if (w_last) begin
`ifdef SD_AUDIO_LOOP_EN
                        r_sec_addr <= START_SEC;
`endif
                    end else begin
                        r_sec_addr <= r_sec_addr + 32'd1;
                    end
                end
                DONE:    if (!play_en) r_sec_addr <= START_SEC;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_ref) begin
        if (w_wr_en) r_mem[r_wr_cnt[8:0]] <= rd_val_data;
    end

    // Level is the registered difference of the next-cycle counts, so it tracks the pointers exactly.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_level        <= '0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_wr_cnt       <= w_wr_cnt_nxt;
            r_rd_cnt       <= w_rd_cnt_nxt;
            r_level        <= w_wr_cnt_nxt - w_rd_cnt_nxt;
            r_sample_valid <= w_rd_en;
            if (w_rd_en) r_sample_data <= r_mem[r_rd_cnt[8:0]];
            if (sample_req && w_empty) r_underrun <= 1'b1;
        end
    end

    assign rd_start_en  = w_start;
    assign rd_sec_addr  = r_sec_addr;
    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign fifo_level   = r_level;
    assign underrun     = r_underrun;
    assign sec_err      = r_sec_err;
    assign play_done    = w_done;

endmodule

// File: tb/tb_sd_audio_reader.sv
// Scoreboard bench for sd_audio_reader: SD read-port model pushes expected words, a monitor pops on sample_valid.
module tb_sd_audio_reader;

    localparam int unsigned BUSY_TMO_V = 20;

    logic        clk_ref = 1'b0;
    logic        rst_n;
    logic        sd_init_done;
    logic        play_en;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        sample_req;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic [9:0]  fifo_level;
    logic        underrun;
    logic        sec_err;
    logic        play_done;

    sd_audio_reader #(
        .START_SEC (32'd0),
        .SEC_NUM   (32'd3),
        .BUSY_TMO  (8'd20)
    ) dut (
        .clk_ref      (clk_ref),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .play_en      (play_en),
        .rd_busy      (rd_busy),
        .rd_val_en    (rd_val_en),
        .rd_val_data  (rd_val_data),
        .rd_start_en  (rd_start_en),
        .rd_sec_addr  (rd_sec_addr),
        .sample_req   (sample_req),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .sec_err      (sec_err),
        .play_done    (play_done)
    );

    always #5 clk_ref = ~clk_ref;

    typedef enum int {M_NORMAL, M_SHORT, M_NOBUSY} mode_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    logic [15:0] sb[$];
    mode_t       modes[$];
    logic [31:0] st_addr[$];
    logic [9:0]  st_lvl[$];
    logic        st_err[$];
    int unsigned st_cyc[$];
    logic        model_active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_ref) cyc <= cyc + 1;

    // Start-pulse logger
    initial forever begin
        @(negedge clk_ref);
        if (rd_start_en === 1'b1) begin
            st_addr.push_back(rd_sec_addr);
            st_lvl.push_back(fifo_level);
            st_err.push_back(sec_err);
            st_cyc.push_back(cyc);
        end
    end

    // SD read-engine model
    initial begin
        logic [31:0] a;
        mode_t       m;
        int          nw;
        rd_busy = 1'b0; rd_val_en = 1'b0; rd_val_data = '0;
        forever begin
            @(negedge clk_ref);
            if (rd_start_en === 1'b1) begin
                a = rd_sec_addr;
                m = (modes.size() > 0) ? modes.pop_front() : M_NORMAL;
                if (m != M_NOBUSY) begin
                    model_active = 1'b1;
                    nw = (m == M_SHORT) ? 255 : 256;
                    repeat (2) @(negedge clk_ref);
                    rd_busy = 1'b1;
                    repeat (2) @(negedge clk_ref);
                    for (int w = 0; w < nw; w++) begin
                        rd_val_en   = 1'b1;
                        rd_val_data = {a[7:0], w[7:0]};
                        sb.push_back(rd_val_data);
                        @(negedge clk_ref);
                    end
                    rd_val_en = 1'b0;
                    @(negedge clk_ref);
                    rd_busy = 1'b0;
                    model_active = 1'b0;
                end
            end
        end
    end

    // Sample monitor
    initial forever begin
        @(negedge clk_ref);
        if (sample_valid === 1'b1) begin
            if (sb.size() == 0) chk("sample_unexpected", 32'd1, 32'd0);
            else                chk("sample_data", {16'd0, sample_data}, {16'd0, sb.pop_front()});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic request();
        logic [9:0] l;
        logic       ve;
        logic [9:0] exp;
        @(negedge clk_ref);
        #1;
        l  = fifo_level;
        ve = rd_val_en;
        sample_req = 1'b1;
        exp = l + {9'd0, ve} - {9'd0, (l != 10'd0)};
        @(negedge clk_ref);
        chk(ve ? "level_wr_rd" : "level_rd", {22'd0, fifo_level}, {22'd0, exp});
        #1 sample_req = 1'b0;
        repeat (2) @(negedge clk_ref);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (model_active || rd_busy); i++) @(negedge clk_ref);
        chk("model_idle", {31'd0, model_active}, 32'd0);
        repeat (5) @(negedge clk_ref);
    endtask

    task automatic do_reset();
        @(negedge clk_ref);
        rst_n = 1'b0;
        sb.delete();
        modes.delete();
        repeat (2) @(negedge clk_ref);
        rst_n = 1'b1;
        @(negedge clk_ref);
    endtask

    initial begin
        int unsigned base;
        rst_n = 1'b0; sd_init_done = 1'b0; play_en = 1'b0; sample_req = 1'b0;
        repeat (3) @(negedge clk_ref);
        chk("rst_start", {31'd0, rd_start_en}, 32'd0);
        chk("rst_addr", rd_sec_addr, 32'd0);
        chk("rst_level", {22'd0, fifo_level}, 32'd0);
        chk("rst_flags", {28'd0, sample_valid, underrun, sec_err, play_done}, 32'd0);
        chk("rst_sdata", {16'd0, sample_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk_ref);

        // Request against an empty FIFO
        #1 sample_req = 1'b1;
        @(negedge clk_ref);
        #1 sample_req = 1'b0;
        @(negedge clk_ref);
        chk("empty_valid", {31'd0, sample_valid}, 32'd0);
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        chk("empty_level", {22'd0, fifo_level}, 32'd0);

        // Fill two sectors
        sd_init_done = 1'b1;
        play_en = 1'b1;
        for (int i = 0; i < 3000 && fifo_level != 10'd512; i++) @(negedge clk_ref);
        chk("fill_level", {22'd0, fifo_level}, 32'd512);
        chk("fill_starts", st_addr.size(), 32'd2);
        chk("start0_addr", st_addr[0], 32'd0);
        chk("start1_addr", st_addr[1], 32'd1);
        repeat (60) @(negedge clk_ref);
        chk("no_start_full", st_addr.size(), 32'd2);
        chk("fill_sec_err", {31'd0, sec_err}, 32'd0);

        // Drain at one request per 4 cycles
`ifdef SD_AUDIO_LOOP_EN
        for (int it = 0; it < 3000 && st_addr.size() < 4; it++) request();
        chk("loop_starts", st_addr.size(), 32'd4);
        chk("start2_addr", st_addr[2], 32'd2);
        chk("start3_addr_wrap", st_addr[3], 32'd0);
        chk("loop_no_done", {31'd0, play_done}, 32'd0);
`else
        for (int it = 0; it < 2000 && !(play_done && fifo_level == 10'd0 && sb.size() == 0); it++)
            request();
        chk("drain_sb_empty", sb.size(), 32'd0);
        chk("done_flag", {31'd0, play_done}, 32'd1);
        chk("done_starts", st_addr.size(), 32'd3);
        chk("start2_addr", st_addr[2], 32'd2);
        chk("start2_level_ok", {31'd0, (st_lvl[2] >= 10'd255 && st_lvl[2] <= 10'd256)}, 32'd1);
        repeat (50) @(negedge clk_ref);
        chk("done_no_start", st_addr.size(), 32'd3);
        chk("done_addr_held", rd_sec_addr, 32'd2);
        play_en = 1'b0;
        repeat (2) @(negedge clk_ref);
        chk("done_exit_flag", {31'd0, play_done}, 32'd0);
        chk("done_exit_addr", rd_sec_addr, 32'd0);
`endif
        play_en = 1'b0;
        wait_idle();
        do_reset();

        // Busy timeout then retry of the same sector
        base = st_addr.size();
        modes.push_back(M_NOBUSY);
        play_en = 1'b1;
        for (int i = 0; i < 3000 && st_addr.size() < base + 3; i++) @(negedge clk_ref);
        chk("tmo_starts", st_addr.size() - base, 32'd3);
        chk("tmo_addr_a", st_addr[base], 32'd0);
        chk("tmo_addr_retry", st_addr[base+1], 32'd0);
        chk("tmo_addr_next", st_addr[base+2], 32'd1);
        chk("tmo_err_before", {31'd0, st_err[base]}, 32'd0);
        chk("tmo_err_after", {31'd0, st_err[base+1]}, 32'd1);
        chk("tmo_gap", st_cyc[base+1] - st_cyc[base], BUSY_TMO_V + 1);
        play_en = 1'b0;
        wait_idle();
        do_reset();

        // Short sector, then asynchronous reset mid-READ
        base = st_addr.size();
        modes.push_back(M_SHORT);
        play_en = 1'b1;
        for (int i = 0; i < 3000 && st_addr.size() < base + 2; i++) @(negedge clk_ref);
        chk("short_starts", st_addr.size() - base, 32'd2);
        chk("short_addr0", st_addr[base], 32'd0);
        chk("short_addr_adv", st_addr[base+1], 32'd1);
        chk("short_err_before", {31'd0, st_err[base]}, 32'd0);
        chk("short_err_after", {31'd0, st_err[base+1]}, 32'd1);
        chk("short_level", {22'd0, st_lvl[base+1]}, 32'd255);
        repeat (30) @(negedge clk_ref);
        chk("midread_level_grew", {31'd0, (fifo_level > 10'd255)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", {22'd0, fifo_level}, 32'd0);
        chk("arst_addr", rd_sec_addr, 32'd0);
        chk("arst_flags", {27'd0, rd_start_en, sample_valid, underrun, sec_err, play_done}, 32'd0);
        chk("arst_sdata", {16'd0, sample_data}, 32'd0);
        play_en = 1'b0;
        wait_idle();
        rst_n = 1'b1;
        repeat (2) @(negedge clk_ref);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
